irq_ctrl: RTL

- Memory-mapped interrupt controller for the 6502 system.
- Collects up to 8 peripheral interrupt sources (timer, uart, spi_flash, ps2_kbd, vga vsync, spare) and drives the CPU IRQ input, which is currently tied low.
- Per-source enable, edge/level mode, pending latch, software trigger, and a priority-encoded vector register.
- Sits on the CPU data bus like the other peripherals: 4 registers, selected by the system address decoder.

---
 rtl/irq_ctrl_if.sv | 11 +
 rtl/irq_ctrl.sv | 88 ++++++++
 2 files changed

// File: rtl/irq_ctrl_if.sv
// CPU-side register bus of the interrupt controller: write data, register
// select and qualified write strobe in, registered read data out.
interface irq_ctrl_if;
    logic [7:0] dbr;
    logic [7:0] dbw;
    logic [1:0] addr;
    logic       we;

    modport master (input dbr, output dbw, addr, we);
    modport slave  (output dbr, input dbw, addr, we);
endinterface

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller for the 6502 system: synchronises up to 8
// sources, latches edge/level pending bits and drives a registered CPU IRQ.
module irq_ctrl #(
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            rst,
    irq_ctrl_if.slave       bus,
    input  logic [NSRC-1:0] src,
    output logic            irq
);

    typedef enum logic [1:0] {
        REG_STATUS = 2'd0,
        REG_ENABLE = 2'd1,
        REG_MODE   = 2'd2,
        REG_VECTOR = 2'd3
    } reg_e;

    reg_e            sel;
    logic [NSRC-1:0] s1, s2, s3;
    logic [NSRC-1:0] pending, enable, mode;
    logic [NSRC-1:0] rise, clr, trig, pending_nxt;
    logic [7:0]      masked, rd_data;
    logic            active;
    logic [2:0]      idx;

    assign sel = reg_e'(bus.addr);

    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        clr  = '0;
        trig = '0;
        if (bus.we && sel == REG_STATUS) clr  = bus.dbw[NSRC-1:0];
        if (bus.we && sel == REG_VECTOR) trig = bus.dbw[NSRC-1:0];
    end

    // Edge bits: set (edge or trigger) beats clear. Level bits follow s2.
    // The mode used is the registered one, so a MODE write takes effect next cycle.
    assign rise        = s2 & ~s3;
    assign pending_nxt = (mode & ((pending & ~clr) | rise | trig)) | (~mode & s2);

    assign masked = 8'(pending & enable);

    // Scan from the top so the lowest-numbered request is the last to win.
    always_comb begin
        active = |masked;
        idx    = '0;
        for (int i = 7; i >= 0; i--) begin
            if (masked[i]) idx = 3'(i);
        end
    end

    always_comb begin
        case (sel)
            REG_STATUS: rd_data = 8'(pending);
            REG_ENABLE: rd_data = 8'(enable);
            REG_MODE:   rd_data = 8'(mode);
            default:    rd_data = {active, 4'b0000, idx};
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1      <= '0;
            s2      <= '0;
            s3      <= '0;
            pending <= '0;
            enable  <= '0;
            mode    <= '0;
            bus.dbr <= '0;
            irq     <= 1'b0;
        end else begin
            s1      <= src;
            s2      <= s1;
            s3      <= s2;
            pending <= pending_nxt;
            bus.dbr <= rd_data;
            irq     <= active;
            if (bus.we && sel == REG_ENABLE) enable <= bus.dbw[NSRC-1:0];
            if (bus.we && sel == REG_MODE)   mode   <= bus.dbw[NSRC-1:0];
        end
    end

endmodule
